// File: rtl/fifo_pkg.sv
// Shared types and helpers for the flagged synchronous FIFO.
// Consumers can bundle the FIFO's status outputs into fifo_status_t.
package fifo_pkg;

    typedef struct packed {
        logic full;
        logic almost_full;
        logic empty;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

    // One extra bit so the count can represent 0..Depth inclusive.
    function automatic int unsigned count_width(input int unsigned log_depth);
        return log_depth + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_ctrl.sv
// Control path of sync_fifo_flags: pointers, occupancy count, status decode,
// sticky error flags and the accept (fire) logic.
module sync_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned LogDepth          = 2,
    parameter int unsigned AlmostFullThresh  = 3,
    parameter int unsigned AlmostEmptyThresh = 1,
    localparam int unsigned CntW             = count_width(LogDepth)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr_i,
    input  logic                we_i,
    input  logic                re_i,
    output logic                w_fire_o,
    output logic                r_fire_o,
    output logic [LogDepth-1:0] wr_idx_o,
    output logic [LogDepth-1:0] rd_idx_o,
    output logic [CntW-1:0]     count_o,
    output fifo_status_t        status_o
);

    localparam int unsigned Depth = 2 ** LogDepth;

    logic [CntW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;
    logic            full, empty;

    assign full  = (count_q == CntW'(Depth));
    assign empty = (count_q == '0);

    // clr wins over both requests; a pop frees the slot a same-cycle push needs.
    assign r_fire_o = !clr_i && re_i && !empty;
    assign w_fire_o = !clr_i && we_i && (!full || r_fire_o);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end else begin
            wr_ptr_d = wr_ptr_q + CntW'(w_fire_o);
            rd_ptr_d = rd_ptr_q + CntW'(r_fire_o);
            count_d  = count_q + CntW'(w_fire_o) - CntW'(r_fire_o);
            ovf_d    = ovf_q | (we_i & ~w_fire_o);
            unf_d    = unf_q | (re_i & ~r_fire_o);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign wr_idx_o = wr_ptr_q[LogDepth-1:0];
    assign rd_idx_o = rd_ptr_q[LogDepth-1:0];
    assign count_o  = count_q;

    always_comb begin
        status_o              = '0;
        status_o.full         = full;
        status_o.almost_full  = (count_q >= CntW'(AlmostFullThresh));
        status_o.empty        = empty;
        status_o.almost_empty = (count_q <= CntW'(AlmostEmptyThresh));
        status_o.overflow     = ovf_q;
        status_o.underflow    = unf_q;
    end

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, programmable thresholds, sticky
// error flags, synchronous flush and registered or fall-through read data.
module sync_fifo_flags
    import fifo_pkg::*;
#(
    parameter type         T                 = logic [7:0],
    parameter int unsigned LogDepth          = 2,
    parameter int unsigned AlmostFullThresh  = 2 ** LogDepth - 1,
    parameter int unsigned AlmostEmptyThresh = 1,
    parameter bit          Fwft              = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr_i,
    input  logic            we_i,
    input  T                w_data_i,
    output logic            full_o,
    output logic            almost_full_o,
    input  logic            re_i,
    output T                r_data_o,
    output logic            empty_o,
    output logic            almost_empty_o,
    output logic [LogDepth:0] count_o,
    output logic            overflow_o,
    output logic            underflow_o
);

    localparam int unsigned Depth = 2 ** LogDepth;

    if (LogDepth < 1) begin : g_bad_log_depth
        $error("sync_fifo_flags: LogDepth must be >= 1");
    end
    if (AlmostFullThresh < 1 || AlmostFullThresh > Depth) begin : g_bad_af
        $error("sync_fifo_flags: AlmostFullThresh must be in 1..Depth");
    end
    if (AlmostEmptyThresh > Depth - 1) begin : g_bad_ae
        $error("sync_fifo_flags: AlmostEmptyThresh must be in 0..Depth-1");
    end

    logic                w_fire, r_fire;
    logic [LogDepth-1:0] wr_idx, rd_idx;
    fifo_status_t        status;

    sync_fifo_ctrl #(
        .LogDepth          (LogDepth),
        .AlmostFullThresh  (AlmostFullThresh),
        .AlmostEmptyThresh (AlmostEmptyThresh)
    ) u_ctrl (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (clr_i),
        .we_i     (we_i),
        .re_i     (re_i),
        .w_fire_o (w_fire),
        .r_fire_o (r_fire),
        .wr_idx_o (wr_idx),
        .rd_idx_o (rd_idx),
        .count_o  (count_o),
        .status_o (status)
    );

    // Storage is deliberately not reset.
    T mem_q [Depth];

    always_ff @(posedge clk) begin
        if (w_fire) begin
            mem_q[wr_idx] <= w_data_i;
        end
    end

    if (Fwft) begin : g_fwft
        assign r_data_o = status.empty ? T'('0) : mem_q[rd_idx];
    end else begin : g_reg_read
        T r_data_q;
        // Nonblocking read of mem_q gives the old head on a same-index push.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_data_q <= T'('0);
            end else if (r_fire) begin
                r_data_q <= mem_q[rd_idx];
            end
        end
        assign r_data_o = r_data_q;
    end

    assign full_o         = status.full;
    assign almost_full_o  = status.almost_full;
    assign empty_o        = status.empty;
    assign almost_empty_o = status.almost_empty;
    assign overflow_o     = status.overflow;
    assign underflow_o    = status.underflow;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Self-checking bench for sync_fifo_flags: registered-read instance plus an FWFT instance.
module tb_sync_fifo_flags;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-read DUT
    logic       rst_n = 1'b0;
    logic       clr = 1'b0, we = 1'b0, re = 1'b0;
    logic [7:0] w_data = 8'h00;
    logic       full, afull, empty, aempty, ovf, unf;
    logic [7:0] r_data;
    logic [2:0] count;

    // FWFT DUT
    logic       f_rst_n = 1'b0;
    logic       f_clr = 1'b0, f_we = 1'b0, f_re = 1'b0;
    logic [7:0] f_wdata = 8'h00;
    logic       f_full, f_afull, f_empty, f_aempty, f_ovf, f_unf;
    logic [7:0] f_rdata;
    logic [2:0] f_count;

    int errors = 0;
    int checks = 0;

    logic [7:0] sb_q[$];
    logic [7:0] exp_rdata = 8'h00;

    sync_fifo_flags #(
        .T                 (logic [7:0]),
        .LogDepth          (2),
        .AlmostFullThresh  (3),
        .AlmostEmptyThresh (1),
        .Fwft              (1'b0)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .clr_i          (clr),
        .we_i           (we),
        .w_data_i       (w_data),
        .full_o         (full),
        .almost_full_o  (afull),
        .re_i           (re),
        .r_data_o       (r_data),
        .empty_o        (empty),
        .almost_empty_o (aempty),
        .count_o        (count),
        .overflow_o     (ovf),
        .underflow_o    (unf)
    );

    sync_fifo_flags #(
        .T                 (logic [7:0]),
        .LogDepth          (2),
        .AlmostFullThresh  (3),
        .AlmostEmptyThresh (1),
        .Fwft              (1'b1)
    ) dut_fwft (
        .clk            (clk),
        .rst_n          (f_rst_n),
        .clr_i          (f_clr),
        .we_i           (f_we),
        .w_data_i       (f_wdata),
        .full_o         (f_full),
        .almost_full_o  (f_afull),
        .re_i           (f_re),
        .r_data_o       (f_rdata),
        .empty_o        (f_empty),
        .almost_empty_o (f_aempty),
        .count_o        (f_count),
        .overflow_o     (f_ovf),
        .underflow_o    (f_unf)
    );

    // One clock of stimulus on the registered DUT; the scoreboard tracks accepted data.
    task automatic xfer(input logic w, input logic [7:0] d, input logic r, input logic c);
        int   n;
        logic rf, wf;
        n  = sb_q.size();
        rf = !c && r && (n > 0);
        wf = !c && w && ((n < 4) || rf);
        we = w; w_data = d; re = r; clr = c;
        @(posedge clk); #1;
        if (c) sb_q.delete();
        if (rf) exp_rdata = sb_q.pop_front();
        if (wf) sb_q.push_back(d);
        we = 1'b0; re = 1'b0; clr = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
        checks++; if (aempty !== 1'b1) begin errors++; $display("FAIL reset_aempty: got %b want 1", aempty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
        checks++; if (afull !== 1'b0) begin errors++; $display("FAIL reset_afull: got %b want 0", afull); end
        checks++; if ({ovf, unf} !== 2'b00) begin errors++; $display("FAIL reset_err: got %b want 00", {ovf, unf}); end
        checks++; if (r_data !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h want 00", r_data); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        @(negedge clk);
        rst_n = 1'b1; f_rst_n = 1'b1;
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < 4; i++) begin
            xfer(1'b1, 8'(8'h11 * (i + 1)), 1'b0, 1'b0);
            checks++; if (count !== 3'(i + 1)) begin errors++; $display("FAIL fill_count: got %0d want %0d", count, i + 1); end
            checks++; if (aempty !== ((i + 1) <= 1)) begin errors++; $display("FAIL fill_aempty at %0d: got %b", i + 1, aempty); end
            checks++; if (afull !== ((i + 1) >= 3)) begin errors++; $display("FAIL fill_afull at %0d: got %b", i + 1, afull); end
            checks++; if (full !== ((i + 1) == 4)) begin errors++; $display("FAIL fill_full at %0d: got %b", i + 1, full); end
        end
        xfer(1'b1, 8'h55, 1'b0, 1'b0);
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL ovf_count: got %0d want 4", count); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", ovf); end
    endtask

    task automatic test_drain_underflow();
        for (int i = 0; i < 4; i++) begin
            xfer(1'b0, 8'h00, 1'b1, 1'b0);
            checks++; if (r_data !== exp_rdata) begin errors++; $display("FAIL drain_rdata %0d: got %h want %h", i, r_data, exp_rdata); end
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b want 1", empty); end
        xfer(1'b0, 8'h00, 1'b1, 1'b0);
        checks++; if (unf !== 1'b1) begin errors++; $display("FAIL unf_flag: got %b want 1", unf); end
        checks++; if (r_data !== 8'h44) begin errors++; $display("FAIL unf_rdata_hold: got %h want 44", r_data); end
        xfer(1'b0, 8'h00, 1'b0, 1'b1);
        checks++; if ({ovf, unf} !== 2'b00) begin errors++; $display("FAIL clr_errs: got %b want 00", {ovf, unf}); end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 4; i++) xfer(1'b1, 8'(8'h11 * (i + 1)), 1'b0, 1'b0);
        xfer(1'b1, 8'h66, 1'b1, 1'b0);
        checks++; if (r_data !== 8'h11) begin errors++; $display("FAIL fpp_head: got %h want 11", r_data); end
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL fpp_count: got %0d want 4", count); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL fpp_ovf: got %b want 0", ovf); end
        for (int i = 0; i < 4; i++) begin
            xfer(1'b0, 8'h00, 1'b1, 1'b0);
            checks++; if (r_data !== exp_rdata) begin errors++; $display("FAIL fpp_drain %0d: got %h want %h", i, r_data, exp_rdata); end
        end
        checks++; if (r_data !== 8'h66) begin errors++; $display("FAIL fpp_last: got %h want 66", r_data); end
    endtask

    task automatic test_empty_push_pop();
        xfer(1'b1, 8'hFF, 1'b1, 1'b0);
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL epp_count: got %0d want 1", count); end
        checks++; if (unf !== 1'b1) begin errors++; $display("FAIL epp_unf: got %b want 1", unf); end
        checks++; if (r_data !== 8'h66) begin errors++; $display("FAIL epp_rdata_hold: got %h want 66", r_data); end
        xfer(1'b0, 8'h00, 1'b1, 1'b0);
        checks++; if (r_data !== 8'hFF) begin errors++; $display("FAIL epp_pop: got %h want ff", r_data); end
    endtask

    task automatic test_clr();
        for (int i = 1; i <= 5; i++) xfer(1'b1, 8'(i), 1'b0, 1'b0);
        xfer(1'b0, 8'h00, 1'b1, 1'b0);
        checks++; if ((count !== 3'd3) || (ovf !== 1'b1)) begin errors++; $display("FAIL clr_setup: got count %0d ovf %b want 3 1", count, ovf); end
        xfer(1'b1, 8'h77, 1'b0, 1'b1);
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL clr_count: got %0d want 0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL clr_empty: got %b want 1", empty); end
        checks++; if ({ovf, unf} !== 2'b00) begin errors++; $display("FAIL clr_flags: got %b want 00", {ovf, unf}); end
        checks++; if (r_data !== 8'h01) begin errors++; $display("FAIL clr_rdata: got %h want 01", r_data); end
        xfer(1'b1, 8'hA5, 1'b0, 1'b0);
        xfer(1'b0, 8'h00, 1'b1, 1'b0);
        checks++; if (r_data !== 8'hA5) begin errors++; $display("FAIL clr_after: got %h want a5", r_data); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL clr_after_empty: got %b want 1", empty); end
    endtask

    task automatic test_fwft_reset();
        f_we = 1'b1; f_wdata = 8'h3C;
        @(posedge clk); #1;
        f_we = 1'b0;
        checks++; if (f_rdata !== 8'h3C) begin errors++; $display("FAIL fwft_show: got %h want 3c", f_rdata); end
        checks++; if (f_empty !== 1'b0) begin errors++; $display("FAIL fwft_nonempty: got %b want 0", f_empty); end
        f_re = 1'b1;
        @(posedge clk); #1;
        f_re = 1'b0;
        checks++; if (f_empty !== 1'b1) begin errors++; $display("FAIL fwft_pop_empty: got %b want 1", f_empty); end
        f_we = 1'b1; f_wdata = 8'h5A;
        @(posedge clk); #1;
        f_wdata = 8'hC3;
        @(posedge clk); #1;
        f_we = 1'b0;
        checks++; if ((f_count !== 3'd2) || (f_rdata !== 8'h5A)) begin errors++; $display("FAIL fwft_two: got count %0d data %h want 2 5a", f_count, f_rdata); end
        #2;
        f_rst_n = 1'b0;
        #1;
        checks++; if (f_count !== 3'd0) begin errors++; $display("FAIL fwft_async_count: got %0d want 0", f_count); end
        checks++; if (f_empty !== 1'b1) begin errors++; $display("FAIL fwft_async_empty: got %b want 1", f_empty); end
        @(negedge clk);
        f_rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_fill_overflow();
        test_drain_underflow();
        test_full_push_pop();
        test_empty_push_pop();
        test_clr();
        test_fwft_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
